// File: rtl/mem_port_arbiter_2_1_if.sv
// rtl/mem_port_arbiter_2_1_if.sv - requester/memory-port bundle for the 2:1 memory port arbiter
interface mem_port_arbiter_2_1_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic [WIDTH-1:0] addr0;
  logic [WIDTH-1:0] wdata0;
  logic             we0;
  logic             req1;
  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] wdata1;
  logic             we1;
  logic             mem_ready;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             sel;
  logic             mem_valid;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;
  logic             err;

  modport slave (
    input  req0, addr0, wdata0, we0,
    input  req1, addr1, wdata1, we1,
    input  mem_ready,
    output gnt0, gnt1, done0, done1, sel, mem_valid,
    output mem_addr, mem_wdata, mem_we, err
  );

  modport master (
    output req0, addr0, wdata0, we0,
    output req1, addr1, wdata1, we1,
    output mem_ready,
    input  gnt0, gnt1, done0, done1, sel, mem_valid,
    input  mem_addr, mem_wdata, mem_we, err
  );
endinterface

// File: rtl/mem_port_arbiter_2_1.sv
// rtl/mem_port_arbiter_2_1.sv - round-robin 2:1 memory port arbiter with transaction hold and watchdog
module mem_port_arbiter_2_1 #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mem_port_arbiter_2_1_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       gnt0_q, gnt1_q, sel_q, valid_q;
  logic       own_id, own_req;

  // lst names the requester served most recently; on contention the other one wins
  function automatic state_t pick(input logic r0, input logic r1, input logic lst);
    if (r0 && r1) return lst ? G0 : G1;
    else if (r0)  return G0;
    else if (r1)  return G1;
    else          return IDLE;
  endfunction

  assign own_id  = (state_q == G1);
  assign own_req = own_id ? bus.req1 : bus.req0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        state_d = pick(bus.req0, bus.req1, last_q);
        cnt_d   = 8'd0;
      end
      G0, G1: begin
        // completion outranks both a dropped request and watchdog expiry
        if (bus.mem_ready) begin
          last_d  = own_id;
          state_d = pick(bus.req0, bus.req1, own_id);
          cnt_d   = 8'd0;
        end else if (!own_req) begin
          last_d  = own_id;
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          last_d  = own_id;
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      gnt0_q  <= (state_d == G0);
      gnt1_q  <= (state_d == G1);
      sel_q   <= (state_d == G1);
      valid_q <= (state_d == G0) || (state_d == G1);
    end
  end

  logic [WIDTH-1:0] addr_mux, wdata_mux;

  assign addr_mux  = sel_q ? bus.addr1  : bus.addr0;
  assign wdata_mux = sel_q ? bus.wdata1 : bus.wdata0;

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.sel       = sel_q;
  assign bus.mem_valid = valid_q;
  assign bus.done0     = bus.mem_ready & gnt0_q;
  assign bus.done1     = bus.mem_ready & gnt1_q;
  assign bus.mem_addr  = valid_q ? addr_mux  : '0;
  assign bus.mem_wdata = valid_q ? wdata_mux : '0;
  assign bus.mem_we    = valid_q & (sel_q ? bus.we1 : bus.we0);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter_2_1.sv
// tb/tb_mem_port_arbiter_2_1.sv - directed self-checking bench for mem_port_arbiter_2_1
module tb_mem_port_arbiter_2_1;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  mem_port_arbiter_2_1_if #(.WIDTH(32)) bus ();

  mem_port_arbiter_2_1 #(.WIDTH(32), .MAX_WAIT(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    bus.req0 = 0; bus.addr0 = 0; bus.wdata0 = 0; bus.we0 = 0;
    bus.req1 = 0; bus.addr1 = 0; bus.wdata1 = 0; bus.we1 = 0;
    bus.mem_ready = 0;
    step();
    step();
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_valid", bus.mem_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_addr", bus.mem_addr, 0);
    reset_n = 1'b1;

    // single transaction from requester 0
    bus.req0 = 1; bus.addr0 = 32'h0000_1000; bus.wdata0 = 32'hAAAA_5555; bus.we0 = 1;
    step();
    chk("single_gnt0", bus.gnt0, 1);
    chk("single_valid", bus.mem_valid, 1);
    chk("single_sel", bus.sel, 0);
    chk("single_addr", bus.mem_addr, 32'h0000_1000);
    chk("single_wdata", bus.mem_wdata, 32'hAAAA_5555);
    chk("single_we", bus.mem_we, 1);
    chk("single_nodone", bus.done0, 0);
    step();
    chk("single_hold", bus.gnt0, 1);
    bus.mem_ready = 1; bus.req0 = 0;
    #1;
    chk("single_done0", bus.done0, 1);
    chk("single_done1", bus.done1, 0);
    step();
    bus.mem_ready = 0;
    chk("single_idle_gnt0", bus.gnt0, 0);
    chk("single_idle_valid", bus.mem_valid, 0);
    chk("single_idle_addr", bus.mem_addr, 0);

    // contention from reset: strict alternation starting with requester 0
    pulse_reset();
    bus.req0 = 1; bus.addr0 = 32'h0000_00A0; bus.we0 = 1;
    bus.req1 = 1; bus.addr1 = 32'h0000_00B1; bus.we1 = 0;
    step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("alt%0d_gnt0", i), bus.gnt0, (i % 2 == 0));
      chk($sformatf("alt%0d_gnt1", i), bus.gnt1, (i % 2 == 1));
      chk($sformatf("alt%0d_sel", i), bus.sel, (i % 2 == 1));
      chk($sformatf("alt%0d_addr", i), bus.mem_addr, (i % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B1);
      bus.mem_ready = 1;
      #1;
      chk($sformatf("alt%0d_done0", i), bus.done0, (i % 2 == 0));
      chk($sformatf("alt%0d_done1", i), bus.done1, (i % 2 == 1));
      step();
      bus.mem_ready = 0;
    end
    chk("alt_back_g0", bus.gnt0, 1);

    // requester 0 abandons its grant
    bus.req0 = 0; bus.req1 = 0;
    #1;
    chk("abort_nodone", bus.done0, 0);
    step();
    chk("abort_gnt0", bus.gnt0, 0);
    chk("abort_we", bus.mem_we, 0);
    chk("abort_err", bus.err, 0);

    // watchdog on requester 1
    bus.req1 = 1; bus.we1 = 1;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("wd%0d_gnt1", k), bus.gnt1, 1);
      chk($sformatf("wd%0d_done1", k), bus.done1, 0);
      chk($sformatf("wd%0d_err", k), bus.err, 0);
    end
    step();
    bus.req1 = 0;
    chk("wd_gnt1_fall", bus.gnt1, 0);
    chk("wd_err_set", bus.err, 1);
    step();
    chk("wd_err_sticky", bus.err, 1);

    // asynchronous reset in the middle of a G1 grant
    bus.req1 = 1;
    step();
    chk("mid_gnt1", bus.gnt1, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt1", bus.gnt1, 0);
    chk("mid_rst_valid", bus.mem_valid, 0);
    chk("mid_rst_sel", bus.sel, 0);
    chk("mid_rst_err", bus.err, 0);
    bus.req1 = 0;
    reset_n = 1'b1;

    // mem_ready while idle is ignored
    bus.mem_ready = 1;
    #1;
    chk("idle_rdy_done0", bus.done0, 0);
    chk("idle_rdy_done1", bus.done1, 0);
    step();
    chk("idle_rdy_gnt0", bus.gnt0, 0);
    chk("idle_rdy_gnt1", bus.gnt1, 0);
    bus.mem_ready = 0;

    // completion on the watchdog expiry cycle wins
    bus.req0 = 1;
    for (int k = 1; k <= 15; k++) step();
    chk("exp_gnt0", bus.gnt0, 1);
    bus.mem_ready = 1; bus.req0 = 0;
    #1;
    chk("exp_done0", bus.done0, 1);
    step();
    bus.mem_ready = 0;
    chk("exp_gnt0_fall", bus.gnt0, 0);
    chk("exp_err", bus.err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
